// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the stopwatch run-control slice.
// Holds the run-control state encoding and the time-field geometry used by
// the controller, its bus interface and the testbench.
package stopwatch_pkg;

    // Width of every minute/second field carried on the bus.
    localparam int TIME_W = 6;

    // Last legal value of the seconds field before it rolls into minutes.
    localparam int SEC_LAST = 59;

    // Run-control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // True when a minute/second pair matches another minute/second pair.
    function automatic logic time_eq(
        input logic [TIME_W-1:0] a_min,
        input logic [TIME_W-1:0] a_sec,
        input logic [TIME_W-1:0] b_min,
        input logic [TIME_W-1:0] b_sec
    );
        return (a_min == b_min) && (a_sec == b_sec);
    endfunction

endpackage : stopwatch_pkg

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: user-control and display bundle of the stopwatch.
// The master side (buttons / bus strobes) drives the requests and target;
// the slave side (stopwatch_ctrl) drives the time, status and lap results.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic              start;
    logic              pause;
    logic              clear;
    logic              lap;
    logic [TIME_W-1:0] target_min;
    logic [TIME_W-1:0] target_sec;

    logic [TIME_W-1:0] second;
    logic [TIME_W-1:0] minute;
    logic              running;
    logic              paused;
    logic              done;
    logic              alarm;
    logic [TIME_W-1:0] lap_min;
    logic [TIME_W-1:0] lap_sec;
    logic              lap_vld;

    modport master (
        output start, pause, clear, lap, target_min, target_sec,
        input  second, minute, running, paused, done, alarm,
               lap_min, lap_sec, lap_vld
    );

    modport slave (
        input  start, pause, clear, lap, target_min, target_sec,
        output second, minute, running, paused, done, alarm,
               lap_min, lap_sec, lap_vld
    );

endinterface : stopwatch_ctrl_if

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the system clock down to one tick every TICK_DIV
// enabled cycles. The count freezes while en is low, so a paused run resumes
// exactly where it left off; zero forces the count back to 0 and wins over en.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic zero,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick = en && !zero && (count_q == CNT_LAST);

    // Next count: clear on zero, wrap at the last value, otherwise step while enabled.
    always_comb begin
        count_d = count_q;
        if (zero) begin
            count_d = '0;
        end else if (en) begin
            if (count_q == CNT_LAST) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : tick_prescaler

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run-control for the minute/second time base.
// A four-state FSM (IDLE/RUN/PAUSE/DONE) owns the second/minute counters,
// advances them on prescaler ticks, stops on a programmable target or at
// MAX_MIN:59, and optionally captures lap times.
// Optional feature: define STOPWATCH_LAP_EN to build the lap capture
// registers; without it the lap outputs are tied to 0 and lap is ignored.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int MAX_MIN  = 59
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  bus
);

    localparam logic [TIME_W-1:0] SEC_MAX = TIME_W'(SEC_LAST);
    localparam logic [TIME_W-1:0] MIN_MAX = TIME_W'(MAX_MIN);

    state_t            state_q, state_d;
    logic [TIME_W-1:0] sec_q, sec_d;
    logic [TIME_W-1:0] min_q, min_d;
    logic [TIME_W-1:0] tgt_min_q, tgt_min_d;
    logic [TIME_W-1:0] tgt_sec_q, tgt_sec_d;
    logic              alarm_q, alarm_d;

    logic              presc_en;
    logic              presc_zero;
    logic              tick;

    logic [TIME_W-1:0] adv_sec;
    logic [TIME_W-1:0] adv_min;
    logic              at_max;
    logic              target_active;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en),
        .zero (presc_zero),
        .tick (tick)
    );

    // Time one tick ahead of now, plus the saturation and target qualifiers.
    always_comb begin
        adv_sec = sec_q + 1'b1;
        adv_min = min_q;
        if (sec_q == SEC_MAX) begin
            adv_sec = '0;
            adv_min = min_q + 1'b1;
        end
        at_max        = (sec_q == SEC_MAX) && (min_q == MIN_MAX);
        target_active = ((tgt_min_q != '0) || (tgt_sec_q != '0)) &&
                        (tgt_sec_q <= SEC_MAX) && (tgt_min_q <= MIN_MAX);
    end

    // FSM next state, counter updates and prescaler control; clear > pause > start.
    always_comb begin
        state_d    = state_q;
        sec_d      = sec_q;
        min_d      = min_q;
        tgt_min_d  = tgt_min_q;
        tgt_sec_d  = tgt_sec_q;
        alarm_d    = 1'b0;
        presc_en   = 1'b0;
        presc_zero = 1'b0;
        case (state_q)
            IDLE: begin
                presc_zero = 1'b1;
                sec_d      = '0;
                min_d      = '0;
                if (!bus.clear && !bus.pause && bus.start) begin
                    state_d   = RUN;
                    tgt_min_d = bus.target_min;
                    tgt_sec_d = bus.target_sec;
                end
            end
            RUN: begin
                if (bus.clear) begin
                    state_d    = IDLE;
                    sec_d      = '0;
                    min_d      = '0;
                    presc_zero = 1'b1;
                end else if (bus.pause) begin
                    state_d = PAUSE;
                end else begin
                    presc_en = 1'b1;
                    if (tick) begin
                        if (at_max) begin
                            state_d = DONE;
                            alarm_d = 1'b1;
                        end else begin
                            sec_d = adv_sec;
                            min_d = adv_min;
                            if (target_active &&
                                time_eq(adv_min, adv_sec, tgt_min_q, tgt_sec_q)) begin
                                state_d = DONE;
                                alarm_d = 1'b1;
                            end
                        end
                    end
                end
            end
            PAUSE: begin
                if (bus.clear) begin
                    state_d    = IDLE;
                    sec_d      = '0;
                    min_d      = '0;
                    presc_zero = 1'b1;
                end else if (!bus.pause && bus.start) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.clear) begin
                    state_d    = IDLE;
                    sec_d      = '0;
                    min_d      = '0;
                    presc_zero = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                sec_d      = '0;
                min_d      = '0;
                presc_zero = 1'b1;
            end
        endcase
    end

    // State, time, target and alarm registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sec_q     <= '0;
            min_q     <= '0;
            tgt_min_q <= '0;
            tgt_sec_q <= '0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            tgt_min_q <= tgt_min_d;
            tgt_sec_q <= tgt_sec_d;
            alarm_q   <= alarm_d;
        end
    end

    assign bus.second  = sec_q;
    assign bus.minute  = min_q;
    assign bus.running = (state_q == RUN);
    assign bus.paused  = (state_q == PAUSE);
    assign bus.done    = (state_q == DONE);
    assign bus.alarm   = alarm_q;

`ifdef STOPWATCH_LAP_EN
    logic [TIME_W-1:0] lap_min_q, lap_min_d;
    logic [TIME_W-1:0] lap_sec_q, lap_sec_d;
    logic              lap_vld_q, lap_vld_d;

    // Lap capture takes the pre-tick time while running or paused; clear zeroes it.
    always_comb begin
        lap_min_d = lap_min_q;
        lap_sec_d = lap_sec_q;
        lap_vld_d = 1'b0;
        if (bus.clear) begin
            lap_min_d = '0;
            lap_sec_d = '0;
        end else if (bus.lap && ((state_q == RUN) || (state_q == PAUSE))) begin
            lap_min_d = min_q;
            lap_sec_d = sec_q;
            lap_vld_d = 1'b1;
        end
    end

    // Lap registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_min_q <= '0;
            lap_sec_q <= '0;
            lap_vld_q <= 1'b0;
        end else begin
            lap_min_q <= lap_min_d;
            lap_sec_q <= lap_sec_d;
            lap_vld_q <= lap_vld_d;
        end
    end

    assign bus.lap_min = lap_min_q;
    assign bus.lap_sec = lap_sec_q;
    assign bus.lap_vld = lap_vld_q;
`else
    assign bus.lap_min = '0;
    assign bus.lap_sec = '0;
    assign bus.lap_vld = 1'b0;
`endif

endmodule : stopwatch_ctrl

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed self-checking bench for stopwatch_ctrl with
// TICK_DIV=4 and MAX_MIN=2. Inputs change and outputs are sampled 1 time
// unit after each rising edge; expected values are hand-computed.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(
        .TICK_DIV (4),
        .MAX_MIN  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sw_if)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges, landing 1 unit after the last one.
    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one cycle of request strobes, then drop them all.
    task automatic applyStimulus(input logic s, input logic p, input logic c, input logic l);
        sw_if.start = s;
        sw_if.pause = p;
        sw_if.clear = c;
        sw_if.lap   = l;
        waitCycles(1);
        sw_if.start = 1'b0;
        sw_if.pause = 1'b0;
        sw_if.clear = 1'b0;
        sw_if.lap   = 1'b0;
    endtask

    // One comparison: count it, and report observed/expected on a miss.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Check the whole visible time/status picture in one call.
    task automatic checkState(input string tag, input int mn, input int sc,
                              input int run, input int pau, input int dn, input int alm);
        checkOutput({tag, ".minute"},  int'(sw_if.minute),  mn);
        checkOutput({tag, ".second"},  int'(sw_if.second),  sc);
        checkOutput({tag, ".running"}, int'(sw_if.running), run);
        checkOutput({tag, ".paused"},  int'(sw_if.paused),  pau);
        checkOutput({tag, ".done"},    int'(sw_if.done),    dn);
        checkOutput({tag, ".alarm"},   int'(sw_if.alarm),   alm);
    endtask

    initial begin
        compared         = 0;
        mismatched       = 0;
        rst              = 1'b1;
        sw_if.start      = 1'b0;
        sw_if.pause      = 1'b0;
        sw_if.clear      = 1'b0;
        sw_if.lap        = 1'b0;
        sw_if.target_min = '0;
        sw_if.target_sec = '0;

        // Reset state.
        waitCycles(2);
        checkState("reset", 0, 0, 0, 0, 0, 0);
        checkOutput("reset.lap_vld", int'(sw_if.lap_vld), 0);
        checkOutput("reset.lap_sec", int'(sw_if.lap_sec), 0);
        rst = 1'b0;
        waitCycles(1);

        // Target 0:03: seconds every 4 cycles, alarm with 0:03.
        $display("[TB] target 0:03 run");
        sw_if.target_sec = 6'd3;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        sw_if.target_sec = 6'd2;
        checkState("t03.start", 0, 0, 1, 0, 0, 0);
        waitCycles(3);
        checkOutput("t03.e3.second", int'(sw_if.second), 0);
        waitCycles(1);
        checkOutput("t03.e4.second", int'(sw_if.second), 1);
        waitCycles(4);
        checkOutput("t03.e8.second", int'(sw_if.second), 2);
        waitCycles(3);
        checkState("t03.e11", 0, 2, 1, 0, 0, 0);
        waitCycles(1);
        checkState("t03.e12", 0, 3, 0, 0, 1, 1);
        waitCycles(1);
        checkState("t03.e13", 0, 3, 0, 0, 1, 0);
        sw_if.target_sec = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(1);
        checkState("t03.start_ignored", 0, 3, 0, 0, 1, 0);

        // Target 0:00 is disabled: run saturates at 2:59.
        $display("[TB] saturation run");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkState("sat.cleared", 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(239);
        checkState("sat.e239", 0, 59, 1, 0, 0, 0);
        waitCycles(1);
        checkState("sat.e240", 1, 0, 1, 0, 0, 0);
        waitCycles(475);
        checkState("sat.e715", 2, 58, 1, 0, 0, 0);
        waitCycles(1);
        checkState("sat.e716", 2, 59, 1, 0, 0, 0);
        waitCycles(3);
        checkState("sat.e719", 2, 59, 1, 0, 0, 0);
        waitCycles(1);
        checkState("sat.e720", 2, 59, 0, 0, 1, 1);
        waitCycles(1);
        checkState("sat.e721", 2, 59, 0, 0, 1, 0);
        waitCycles(4);
        checkState("sat.hold", 2, 59, 0, 0, 1, 0);

        // Pause 5 cycles at prescaler=2: tick moves from E0+4 to E0+9.
        $display("[TB] pause/resume run");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkState("pau.e3", 0, 0, 0, 1, 0, 0);
        waitCycles(3);
        checkState("pau.e6", 0, 0, 0, 1, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkState("pau.resume", 0, 0, 1, 0, 0, 0);
        waitCycles(1);
        checkOutput("pau.e8.second", int'(sw_if.second), 0);
        waitCycles(1);
        checkOutput("pau.e9.second", int'(sw_if.second), 1);

        // clear, pause and start together: clear wins.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkState("all3", 0, 0, 0, 0, 0, 0);

        // Reset mid-run at 1:17, then restart from 0:00.
        $display("[TB] mid-run reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(308);
        checkState("rst.e308", 1, 17, 1, 0, 0, 0);
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        checkState("rst.after", 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkState("rst.restart", 0, 0, 1, 0, 0, 0);
        waitCycles(4);
        checkOutput("rst.restart.e4.second", int'(sw_if.second), 1);

        // Lap on the tick cycle 0:05 -> 0:06 captures the pre-tick time.
        $display("[TB] lap capture");
        waitCycles(19);
        checkOutput("lap.pre.second", int'(sw_if.second), 5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("lap.post.second", int'(sw_if.second), 6);
`ifdef STOPWATCH_LAP_EN
        checkOutput("lap.vld", int'(sw_if.lap_vld), 1);
        checkOutput("lap.sec", int'(sw_if.lap_sec), 5);
        checkOutput("lap.min", int'(sw_if.lap_min), 0);
        waitCycles(1);
        checkOutput("lap.vld_drop", int'(sw_if.lap_vld), 0);
        checkOutput("lap.sec_hold", int'(sw_if.lap_sec), 5);
`else
        checkOutput("lap.vld", int'(sw_if.lap_vld), 0);
        checkOutput("lap.sec", int'(sw_if.lap_sec), 0);
        checkOutput("lap.min", int'(sw_if.lap_min), 0);
        waitCycles(1);
        checkOutput("lap.vld_later", int'(sw_if.lap_vld), 0);
        checkOutput("lap.sec_later", int'(sw_if.lap_sec), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_stopwatch_ctrl
